maxpool_channel_sched: RTL and testbench

MAXPOOL_CHANNEL_SCHED -- requirements
Module: maxpool_channel_sched

---
 rtl/maxpool_pkg.sv | 15 +
 rtl/pool_lat_timer.sv | 28 ++
 rtl/maxpool_channel_sched.sv | 118 +++++++++++
 tb/tb_maxpool_channel_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types for the maxpool channel scheduler.
// Holds the FSM state encoding and the pool-latency counter width.
package maxpool_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pool_lat_timer.sv
// Loadable down-counter with a zero flag.
// Times the WAIT phase while the pool datapath settles.
module pool_lat_timer
    import maxpool_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/maxpool_channel_sched.sv
// Sequences D channels through a shared max-pool datapath.
// Optional MAXPOOL_SCHED_PERF_EN adds the perf_cycles busy-cycle counter.
module maxpool_channel_sched
    import maxpool_pkg::*;
#(
    parameter int D        = 6,
    parameter int POOL_LAT = 2,
    parameter int CH_W     = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic [CH_W-1:0] ch_idx,
    output logic            in_load,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic            busy,
`ifdef MAXPOOL_SCHED_PERF_EN
    output logic [15:0]     perf_cycles,
`endif
    output logic            done
);

    localparam logic [CH_W-1:0] LAST = CH_W'(D - 1);
    // WAIT exits on the zero flag, so load one less than the latency
    localparam logic [LAT_W-1:0] LAT_LD =
        LAT_W'((POOL_LAT == 0) ? 0 : POOL_LAT - 1);

    state_t          state, state_n;
    logic [CH_W-1:0] ch_n;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;

    pool_lat_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (LAT_LD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_n;
            ch_idx <= ch_n;
        end
    end

    always_comb begin
        state_n  = state;
        ch_n     = ch_idx;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ch_n = '0;
                if (start) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                tmr_load = 1'b1;
                state_n  = (POOL_LAT == 0) ? ST_OUT : ST_WAIT;
            end
            ST_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_n = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (ch_idx == LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_LOAD;
                        ch_n    = ch_idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                ch_n    = '0;
            end
            default: begin
                state_n = ST_IDLE;
                ch_n    = '0;
            end
        endcase
        // abort overrides start and out_ready in every state
        if (abort) begin
            state_n = ST_IDLE;
            ch_n    = '0;
        end
    end

    assign in_load   = (state == ST_LOAD);
    assign out_valid = (state == ST_OUT);
    assign out_ch    = ch_idx;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef MAXPOOL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (state == ST_IDLE && start && !abort) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_channel_sched.sv
// Directed table-driven bench for maxpool_channel_sched (D=6, POOL_LAT=2).
// Cycle c is the interval after clock edge c-1; inputs of cycle c are sampled at edge c.
module tb_maxpool_channel_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic [2:0] ch_idx;
    logic [2:0] out_ch;
    logic       in_load;
    logic       out_valid;
    logic       busy;
    logic       done;
`ifdef MAXPOOL_SCHED_PERF_EN
    logic [15:0] perf_cycles;
`endif

    maxpool_channel_sched #(.D(6), .POOL_LAT(2), .CH_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ch_idx      (ch_idx),
        .in_load     (in_load),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .busy        (busy),
`ifdef MAXPOOL_SCHED_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic       rdy;
        logic       ld;
        logic       vld;
        logic       dn;
        logic       bsy;
        logic [2:0] ch;
    } vec_t;

    vec_t vec[64];
    int   nvec;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected trace of one full pass, optionally stalling one channel
    task automatic build_pass(input int stall_ch, input int stall_n,
                              input int extra_start);
        int t;
        int v;
        int s;
        for (int i = 0; i < 64; i++) begin
            vec[i] = '{start: 1'b0, abort: 1'b0, rdy: 1'b1, ld: 1'b0,
                       vld: 1'b0, dn: 1'b0, bsy: 1'b0, ch: 3'd0};
        end
        vec[0].start = 1'b1;
        t = 1;
        for (int k = 0; k < 6; k++) begin
            s = (k == stall_ch) ? stall_n : 0;
            v = t + 3;
            vec[t].ld = 1'b1;
            vec[t].ch = 3'(k);
            for (int j = t; j <= v + s; j++) vec[j].bsy = 1'b1;
            for (int j = 0; j <= s; j++) begin
                vec[v+j].vld = 1'b1;
                vec[v+j].ch  = 3'(k);
                if (j < s) vec[v+j].rdy = 1'b0;
            end
            t = v + s + 1;
        end
        vec[t].dn  = 1'b1;
        vec[t].bsy = 1'b1;
        nvec = t + 2;
        if (extra_start >= 0) vec[extra_start].start = 1'b1;
    endtask

    task automatic run_table();
        for (int c = 0; c < nvec; c++) begin
            start     = vec[c].start;
            abort     = vec[c].abort;
            out_ready = vec[c].rdy;
            check($sformatf("in_load@%0d", c), int'(in_load), int'(vec[c].ld));
            check($sformatf("out_valid@%0d", c), int'(out_valid), int'(vec[c].vld));
            check($sformatf("done@%0d", c), int'(done), int'(vec[c].dn));
            check($sformatf("busy@%0d", c), int'(busy), int'(vec[c].bsy));
            if (vec[c].ld)
                check($sformatf("ch_idx@%0d", c), int'(ch_idx), int'(vec[c].ch));
            if (vec[c].vld)
                check($sformatf("out_ch@%0d", c), int'(out_ch), int'(vec[c].ch));
            tick();
        end
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_in_load"}, int'(in_load), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ch_idx"}, int'(ch_idx), 0);
        check({tag, "_out_ch"}, int'(out_ch), 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
`ifdef MAXPOOL_SCHED_PERF_EN
        check("reset_perf", int'(perf_cycles), 0);
`endif
        #1 reset = 1'b0;
        tick();

        // Plain pass: done at cycle 25
        build_pass(-1, 0, -1);
        run_table();
`ifdef MAXPOOL_SCHED_PERF_EN
        check("perf_plain", int'(perf_cycles), 25);
`endif

        // Channel 2 held off for 3 cycles: done at cycle 28
        build_pass(2, 3, -1);
        run_table();
`ifdef MAXPOOL_SCHED_PERF_EN
        check("perf_stall", int'(perf_cycles), 28);
`endif

        // Stray start mid-pass is ignored
        build_pass(-1, 0, 10);
        run_table();

        // Abort during channel 3 WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check("abort_pre_busy", int'(busy), 1);
        check("abort_pre_ch", int'(ch_idx), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_ch", int'(ch_idx), 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_done@%0d", i), int'(done), 0);
            check($sformatf("abort_vld@%0d", i), int'(out_valid), 0);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_load", int'(in_load), 1);
        check("restart_ch", int'(ch_idx), 0);
        for (int i = 0; i < 3; i++) tick();
        check("restart_vld", int'(out_valid), 1);
        check("restart_out_ch", int'(out_ch), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", int'(busy), 0);
        check("sa_in_load", int'(in_load), 0);
        tick();
        check("sa_busy2", int'(busy), 0);

        // Asynchronous reset mid-WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_pre_busy", int'(busy), 1);
        #3 reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
`ifdef MAXPOOL_SCHED_PERF_EN
        check("rst_mid_perf", int'(perf_cycles), 0);
`endif
        #1 reset = 1'b0;
        tick();
        check("rst_idle", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_restart_load", int'(in_load), 1);
        check("rst_restart_ch", int'(ch_idx), 0);
        for (int i = 0; i < 3; i++) tick();
        check("rst_restart_out_ch", int'(out_ch), 0);
        check("rst_restart_vld", int'(out_valid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
